// File: rtl/uart_echo_fifo.sv
// UART receiver/transmitter with an oversampling tick generator and an RX->TX echo FIFO.
// Optional even parity on every frame is enabled by defining UART_PARITY_EN.

module uart_echo_fifo #(
    parameter int DATA_W  = 8,
    parameter int OVS     = 16,
    parameter int OVS_DIV = 27,
    parameter int FIFO_AW = 4
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx,
    output logic              tx,
    input  logic              echo_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              tx_busy
);

    localparam int CW    = $clog2(OVS_DIV);
    localparam int SW    = $clog2(OVS);
    localparam int BW    = $clog2(DATA_W);
    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    logic [CW-1:0] div_q;
    logic          tick;
    logic          tx_tick;

    assign tick    = (div_q == CW'(OVS_DIV - 1));
    assign tx_tick = tick;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= tick ? '0 : div_q + CW'(1);
    end

    logic rx_meta_q, rxs_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t         rx_st_q, rx_st_d;
    logic [SW-1:0]     rx_sub_q, rx_sub_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              armed_q, armed_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              push_q, push_d;
    logic              rx_par_ok;

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;
    assign rx_par_ok = ~par_err_q;
`else
    assign rx_par_ok = 1'b1;
`endif

    always_comb begin
        rx_st_d     = rx_st_q;
        rx_sub_d    = rx_sub_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        armed_d     = armed_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        push_d      = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (tick) begin
            rx_sub_d = rx_sub_q + SW'(1);
            case (rx_st_q)
                // armed_q blocks re-triggering until the line has been seen high again
                RX_IDLE: begin
                    if (rxs_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d  = 1'b0;
                        rx_sub_d = '0;
                        rx_st_d  = RX_START;
                    end
                end
                RX_START: begin
                    if (rx_sub_q == SW'(OVS / 2 - 1)) begin
                        rx_sub_d = '0;
                        rx_bit_d = '0;
                        rx_st_d  = rxs_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sub_q == SW'(OVS - 1)) begin
                        rx_sub_d = '0;
                        rx_sh_d  = {rxs_q, rx_sh_q[DATA_W-1:1]};
                        if (rx_bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            rx_st_d = RX_PAR;
`else
                            rx_st_d = RX_STOP;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + BW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PAR: begin
                    if (rx_sub_q == SW'(OVS - 1)) begin
                        rx_sub_d  = '0;
                        par_err_d = rxs_q ^ (^rx_sh_q);
                        rx_st_d   = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_sub_q == SW'(OVS - 1)) begin
                        rx_sub_d = '0;
                        rx_st_d  = RX_IDLE;
                        if (rxs_q && rx_par_ok) begin
                            rx_data_d  = rx_sh_q;
                            rx_valid_d = 1'b1;
                            push_d     = echo_en;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: rx_st_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_st_q     <= RX_IDLE;
            rx_sub_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            armed_q     <= 1'b1;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_st_q     <= rx_st_d;
            rx_sub_q    <= rx_sub_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            armed_q     <= armed_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
`ifdef UART_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // ---------------- echo FIFO ----------------
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic               overflow_q;
    logic               pop;
    logic               push_ok;

    // level never exceeds DEPTH, so its MSB alone marks full
    assign push_ok = push_q && (!level_q[FIFO_AW] || pop);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (push_ok && !pop)      level_q <= level_q + LW'(1);
            else if (!push_ok && pop) level_q <= level_q - LW'(1);
            if (push_q && !push_ok) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_data_q;
    end

    // ---------------- transmitter ----------------
    tx_state_t         tx_st_q, tx_st_d;
    logic [SW-1:0]     tx_sub_q, tx_sub_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_q, tx_d;
    logic              tx_end;
    logic              tx_load;

`ifdef UART_PARITY_EN
    logic tx_par_q, tx_par_d;
`endif

    assign tx_end = (tx_sub_q == SW'(OVS - 1));
    assign pop    = tx_load;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_sub_d = tx_sub_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_d     = tx_q;
        tx_load  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d = tx_par_q;
`endif
        if (tx_tick) begin
            tx_sub_d = tx_end ? '0 : tx_sub_q + SW'(1);
            case (tx_st_q)
                TX_IDLE: tx_load = (level_q != '0);
                TX_START: begin
                    if (tx_end) begin
                        tx_d     = tx_sh_q[0];
                        tx_bit_d = '0;
                        tx_st_d  = TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_end) begin
                        if (tx_bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            tx_d    = tx_par_q;
                            tx_st_d = TX_PAR;
`else
                            tx_d    = 1'b1;
                            tx_st_d = TX_STOP;
`endif
                        end else begin
                            tx_bit_d = tx_bit_q + BW'(1);
                            tx_sh_d  = tx_sh_q >> 1;
                            tx_d     = tx_sh_q[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PAR: begin
                    if (tx_end) begin
                        tx_d    = 1'b1;
                        tx_st_d = TX_STOP;
                    end
                end
`endif
                // a queued word starts on the tick that ends STOP, keeping frames gapless
                TX_STOP: begin
                    if (tx_end) begin
                        tx_st_d = TX_IDLE;
                        tx_load = (level_q != '0);
                    end
                end
                default: tx_st_d = TX_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_sh_d  = mem_q[rd_ptr_q];
            tx_d     = 1'b0;
            tx_sub_d = '0;
            tx_st_d  = TX_START;
`ifdef UART_PARITY_EN
            tx_par_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_st_q  <= TX_IDLE;
            tx_sub_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else begin
            tx_st_q  <= tx_st_d;
            tx_sub_q <= tx_sub_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_q     <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q <= tx_par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
    assign tx_busy    = (tx_st_q != TX_IDLE);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo (OVS=16, OVS_DIV=4: 64-cycle bit period).

module tb_uart_echo_fifo;

    localparam int BIT = 64;
    localparam logic [7:0] OVF_W [17] = '{
        8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89,
        8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'hEF, 8'hF0, 8'h0F
    };

    logic       sysclk = 1'b0;
    logic       reset;
    logic       rx;
    logic       tx;
    logic       echo_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [4:0] fifo_level;
    logic       tx_busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_echo_fifo #(
        .DATA_W (8),
        .OVS    (16),
        .OVS_DIV(4),
        .FIFO_AW(4)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .echo_en   (echo_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fifo_level(fifo_level),
        .tx_busy   (tx_busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic drive_frame(input logic [7:0] d, input logic stop_b);
        rx = 1'b0;
        repeat (BIT) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge sysclk);
        end
        rx = stop_b;
        repeat (BIT) @(negedge sysclk);
        rx = 1'b1;
    endtask

    // Waits for a start bit and samples every bit at its centre.
    task automatic capture_tx(output logic found, output logic [7:0] d, output logic stop_b);
        found  = 1'b0;
        d      = '0;
        stop_b = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge sysclk);
            if (tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (BIT / 2) @(negedge sysclk);
            for (int b = 0; b < 8; b++) begin
                repeat (BIT) @(negedge sysclk);
                d[b] = tx;
            end
            repeat (BIT) @(negedge sysclk);
            stop_b = tx;
        end
    endtask

    task automatic test_reset();
        int pulses;
        pulses  = 0;
        rx      = 1'b1;
        echo_en = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sysclk);
            if (rx_valid !== 1'b0 || frame_err !== 1'b0 || tx !== 1'b1) pulses++;
        end
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL reset_idle_activity: got %0d cycles expected 0", pulses); end
    endtask

    task automatic test_echo();
        int         vcnt;
        logic [7:0] vdata;
        logic       saw1, saw0, found;
        logic [9:0] exp_bits;
        vcnt     = 0;
        vdata    = '0;
        saw1     = 1'b0;
        saw0     = 1'b0;
        found    = 1'b0;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        echo_en  = 1'b1;
        fork
            drive_frame(8'hA5, 1'b1);
            begin
                for (int c = 0; c < 800; c++) begin
                    @(negedge sysclk);
                    if (rx_valid === 1'b1) begin vcnt++; vdata = rx_data; end
                    if (fifo_level === 5'd1) saw1 = 1'b1;
                    if (saw1 && fifo_level === 5'd0) saw0 = 1'b1;
                end
            end
            begin
                for (int c = 0; c < 1000 && !found; c++) begin
                    @(negedge sysclk);
                    if (tx === 1'b0) found = 1'b1;
                end
                n_cmp++; if (!found) begin n_err++; $display("FAIL echo_tx_start: got none expected start bit"); end
                if (found) begin
                    for (int b = 0; b < 10; b++) begin
                        if (b != 0) begin
                            n_cmp++;
                            if (tx !== exp_bits[b]) begin n_err++; $display("FAIL echo_bit%0d_first: got %b expected %b", b, tx, exp_bits[b]); end
                        end
                        repeat (BIT - 1) @(negedge sysclk);
                        n_cmp++;
                        if (tx !== exp_bits[b]) begin n_err++; $display("FAIL echo_bit%0d_last: got %b expected %b", b, tx, exp_bits[b]); end
                        @(negedge sysclk);
                    end
                end
            end
        join
        repeat (10) @(negedge sysclk);
        n_cmp++; if (vcnt != 1) begin n_err++; $display("FAIL echo_valid_count: got %0d expected 1", vcnt); end
        n_cmp++; if (vdata !== 8'hA5) begin n_err++; $display("FAIL echo_rx_data: got %h expected a5", vdata); end
        n_cmp++; if (!(saw1 && saw0)) begin n_err++; $display("FAIL echo_level_seq: got saw1=%b saw0=%b expected 1 1", saw1, saw0); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL echo_busy_end: got %b expected 0", tx_busy); end
    endtask

    task automatic test_frame_err();
        int vcnt, ecnt, txlow, lvl;
        vcnt = 0; ecnt = 0; txlow = 0; lvl = 0;
        echo_en = 1'b1;
        fork
            drive_frame(8'h3C, 1'b0);
            begin
                for (int c = 0; c < 10 * BIT + 150; c++) begin
                    @(negedge sysclk);
                    if (rx_valid === 1'b1) vcnt++;
                    if (frame_err === 1'b1) ecnt++;
                    if (tx !== 1'b1) txlow++;
                    if (fifo_level !== 5'd0) lvl++;
                end
            end
        join
        n_cmp++; if (ecnt != 1) begin n_err++; $display("FAIL ferr_pulse: got %0d expected 1", ecnt); end
        n_cmp++; if (vcnt != 0) begin n_err++; $display("FAIL ferr_valid: got %0d expected 0", vcnt); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL ferr_rx_data: got %h expected a5", rx_data); end
        n_cmp++; if (txlow != 0 || lvl != 0) begin n_err++; $display("FAIL ferr_no_echo: got txlow=%0d lvl=%0d expected 0 0", txlow, lvl); end
    endtask

    task automatic test_glitch();
        int         bad, vcnt, lvl, txlow;
        logic [7:0] vdata;
        bad = 0; vcnt = 0; lvl = 0; txlow = 0; vdata = '0;
        echo_en = 1'b0;
        rx = 1'b0;
        repeat (20) @(negedge sysclk);
        rx = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge sysclk);
            if (rx_valid !== 1'b0 || frame_err !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL glitch_flags: got %0d expected 0", bad); end
        fork
            drive_frame(8'h5A, 1'b1);
            begin
                for (int c = 0; c < 10 * BIT + 150; c++) begin
                    @(negedge sysclk);
                    if (rx_valid === 1'b1) begin vcnt++; vdata = rx_data; end
                    if (fifo_level !== 5'd0) lvl++;
                    if (tx !== 1'b1) txlow++;
                end
            end
        join
        n_cmp++; if (vcnt != 1 || vdata !== 8'h5A) begin n_err++; $display("FAIL glitch_next_frame: got cnt=%0d data=%h expected 1 5a", vcnt, vdata); end
        n_cmp++; if (lvl != 0 || txlow != 0) begin n_err++; $display("FAIL echo_off_gating: got lvl=%0d txlow=%0d expected 0 0", lvl, txlow); end
    endtask

    task automatic test_overflow();
        logic [4:0] peak;
        logic       found, sb;
        logic [7:0] d;
        peak = '0;
        echo_en = 1'b1;
        force dut.tx_tick = 1'b0;
        fork
            for (int i = 0; i < 17; i++) drive_frame(OVF_W[i], 1'b1);
            begin
                for (int c = 0; c < 17 * 10 * BIT + 100; c++) begin
                    @(negedge sysclk);
                    if (fifo_level > peak) peak = fifo_level;
                end
            end
        join
        n_cmp++; if (peak !== 5'd16) begin n_err++; $display("FAIL ovf_peak: got %0d expected 16", peak); end
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        release dut.tx_tick;
        for (int k = 0; k < 16; k++) begin
            capture_tx(found, d, sb);
            n_cmp++;
            if (!found || d !== OVF_W[k]) begin n_err++; $display("FAIL ovf_word%0d: got found=%b data=%h expected %h", k, found, d, OVF_W[k]); end
            n_cmp++;
            if (sb !== 1'b1) begin n_err++; $display("FAIL ovf_stop%0d: got %b expected 1", k, sb); end
        end
        repeat (BIT) @(negedge sysclk);
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL ovf_drained: got %0d expected 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        logic       found, sb;
        logic [7:0] d, vdata;
        int         vcnt;
        found = 1'b0; vcnt = 0; vdata = '0;
        echo_en = 1'b1;
        force dut.tx_tick = 1'b0;
        drive_frame(8'h0F, 1'b1);
        drive_frame(8'h22, 1'b1);
        release dut.tx_tick;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge sysclk);
            if (tx === 1'b0) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rst_tx_start: got none expected start bit"); end
        repeat (5 * BIT + BIT / 2) @(negedge sysclk);
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_pre_bit4: got %b expected 0", tx); end
        n_cmp++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL rst_pre_level: got %0d expected 1", fifo_level); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
        @(negedge sysclk);
        reset = 1'b0;
        repeat (10) @(negedge sysclk);
        fork
            drive_frame(8'h81, 1'b1);
            begin
                for (int c = 0; c < 800; c++) begin
                    @(negedge sysclk);
                    if (rx_valid === 1'b1) begin vcnt++; vdata = rx_data; end
                end
            end
            capture_tx(found, d, sb);
        join
        n_cmp++; if (vcnt != 1 || vdata !== 8'h81) begin n_err++; $display("FAIL post_rst_rx: got cnt=%0d data=%h expected 1 81", vcnt, vdata); end
        n_cmp++; if (!found || d !== 8'h81) begin n_err++; $display("FAIL post_rst_echo: got found=%b data=%h expected 81", found, d); end
        n_cmp++; if (sb !== 1'b1) begin n_err++; $display("FAIL post_rst_stop: got %b expected 1", sb); end
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        echo_en = 1'b0;
        test_reset();
        test_echo();
        test_frame_err();
        test_glitch();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
